acf_axil_cmd_master: RTL and testbench
======================================

// Module: acf_axil_cmd_master
// PURPOSE
//  AXI4-Lite master placed directly upstream of the ACF_AXI_v1_0 slave's s00_axi port.
//  It turns a simple command stream into single AXI-Lite read or write transactions.
//  It returns one response per command: read data, xRESP, and the bus latency in cycles.
//  Only one transaction is outstanding at a time. AW and W handshakes complete in any order.
// PARAMETERS
//  ADDR_W  32  address width (awaddr/araddr, cmd_addr)
//  DATA_W  32  data width; multiple of 8; strobe width = DATA_W/8
//  PROT    3'b000  constant value driven on awprot/arprot
//  CYC_W   16  width of the saturating latency counter rsp_cycles
// PORTS
//  m00_axi_aclk     in   1         clock; all logic is rising-edge
//  m00_axi_aresetn  in   1         reset, asynchronous, active-low
//  cmd_valid        in   1         command present
//  cmd_ready        out  1         block idle and able to accept a command
//  cmd_write        in   1         1 = write, 0 = read
//  cmd_addr         in   ADDR_W    target byte address
//  cmd_wdata        in   DATA_W    write data (ignored for reads)
//  cmd_wstrb        in   DATA_W/8  write byte strobes (ignored for reads)
//  rsp_valid        out  1         response present; held until rsp_ready
//  rsp_ready        in   1         consumer accepts the response
//  rsp_write        out  1         echo of cmd_write
//  rsp_rdata        out  DATA_W    read data; 0 for writes
//  rsp_resp         out  2         captured BRESP or RRESP
//  rsp_cycles       out  CYC_W     clock cycles spent in bus states (saturating)
//  m00_axi_aw{addr,prot,valid} out / awready in   write address channel
//  m00_axi_w{data,strb,valid} out / wready in     write data channel
//  m00_axi_b{resp,valid} in / bready out          write response channel
//  m00_axi_ar{addr,prot,valid} out / arready in   read address channel
//  m00_axi_r{data,resp,valid} in / rready out     read data channel
// BEHAVIOUR
//  Reset (async): state=IDLE. All registered outputs and the latched command/response are 0.
//  cmd_ready = (state==IDLE); it is decoded from the registered state only.
//  States: IDLE, WR, WR_B, RD_A, RD_D, RSP. Every AXI valid/ready output is registered.
//  IDLE: on cmd_valid & cmd_ready, latch cmd_*, clear rsp_cycles and done flags.
//   Write command -> WR, with awvalid=wvalid=1 from the next cycle.
//   Read command -> RD_A, with arvalid=1 from the next cycle.
//  WR: awaddr/wdata/wstrb hold the latched values.
//   aw_done sets when awvalid & awready; awvalid drops on the following cycle.
//   w_done sets when wvalid & wready; wvalid drops on the following cycle.
//   When both are done (same cycle or different cycles) -> WR_B, with bready=1 next cycle.
//   Valid is never withdrawn before its handshake.
//  WR_B: on bvalid & bready, capture bresp into rsp_resp and set rsp_rdata=0.
//   Then bready=0 -> RSP.
//  RD_A: on arvalid & arready, arvalid=0 and rready=1 -> RD_D.
//  RD_D: on rvalid & rready, capture rdata/rresp and set rready=0 -> RSP.
//  RSP: rsp_valid=1; rsp_* are stable while rsp_valid=1.
//   On rsp_ready -> IDLE. rsp_valid falls on the next edge, so back-to-back cmd accept is possible then.
//  rsp_cycles: +1 on every clock spent in WR, WR_B, RD_A or RD_D. Saturates at 2^CYC_W-1.
//  A non-OKAY xRESP is only reported; it is never retried.
//  wstrb=0 is issued unchanged on the bus.
//  cmd_* inputs are ignored outside the IDLE handshake. The latched values do not change mid-transaction.
//  Reset asserted mid-transaction: all valid/ready outputs drop immediately, the command is lost, no response is produced.
//   After release: IDLE, cmd_ready=1 on the first clock.
// TESTING
//  1 Write addr 0x0, data 0x5, strb 0xF; slave awready=wready=1 immediately, bvalid next cycle, bresp=0
//    -> aw/wvalid high 1 cycle; rsp_write=1, rsp_resp=0, rsp_rdata=0, rsp_cycles=2.
//  2 Write; wready 3 cycles before awready -> exactly one W and one AW handshake;
//    wvalid low while awvalid still high; rsp only after B.
//  3 Read addr 0x4; arready after 2 cycles, rvalid 1 cycle later with 0xDEADBEEF, rresp=0
//    -> rsp_rdata=0xDEADBEEF, rsp_write=0, rsp_cycles=4.
//  4 rsp_ready low 5 cycles after rsp_valid -> rsp_* stable, cmd_ready=0,
//    second cmd_valid not accepted until the cycle after rsp_ready.
//  5 Reset pulsed while in WR_B -> bready/valids 0 immediately, no rsp_valid;
//    cmd_ready=1 after release, next read completes normally.
//  6 CYC_W=8, slave withholds arready 300 cycles -> rsp_cycles=255; bresp=2'b10 on a write -> rsp_resp=2'b10.

Source files
------------

// File: rtl/acf_axil_cmd_master.sv
// AXI4-Lite master: one command in, one single-beat AXI-Lite transaction out,
// one response back with data, xRESP and bus latency.
module acf_axil_cmd_master #(
    parameter int          ADDR_W = 32,
    parameter int          DATA_W = 32,
    parameter logic [2:0]  PROT   = 3'b000,
    parameter int          CYC_W  = 16
) (
    input  logic                  m00_axi_aclk,
    input  logic                  m00_axi_aresetn,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic [CYC_W-1:0]      rsp_cycles,

    output logic [ADDR_W-1:0]     m00_axi_awaddr,
    output logic [2:0]            m00_axi_awprot,
    output logic                  m00_axi_awvalid,
    input  logic                  m00_axi_awready,

    output logic [DATA_W-1:0]     m00_axi_wdata,
    output logic [DATA_W/8-1:0]   m00_axi_wstrb,
    output logic                  m00_axi_wvalid,
    input  logic                  m00_axi_wready,

    input  logic [1:0]            m00_axi_bresp,
    input  logic                  m00_axi_bvalid,
    output logic                  m00_axi_bready,

    output logic [ADDR_W-1:0]     m00_axi_araddr,
    output logic [2:0]            m00_axi_arprot,
    output logic                  m00_axi_arvalid,
    input  logic                  m00_axi_arready,

    input  logic [DATA_W-1:0]     m00_axi_rdata,
    input  logic [1:0]            m00_axi_rresp,
    input  logic                  m00_axi_rvalid,
    output logic                  m00_axi_rready
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_B,
        RD_A,
        RD_D,
        RSP
    } state_t;

    state_t              state;
    logic                write_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic                aw_done;
    logic                w_done;

    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic ar_hs;
    logic r_hs;
    logic on_bus;
    logic cyc_max;

    assign aw_hs   = m00_axi_awvalid & m00_axi_awready;
    assign w_hs    = m00_axi_wvalid & m00_axi_wready;
    assign b_hs    = m00_axi_bvalid & m00_axi_bready;
    assign ar_hs   = m00_axi_arvalid & m00_axi_arready;
    assign r_hs    = m00_axi_rvalid & m00_axi_rready;
    assign on_bus  = (state == WR) || (state == WR_B) ||
                     (state == RD_A) || (state == RD_D);
    assign cyc_max = &rsp_cycles;

    assign cmd_ready      = (state == IDLE);
    assign rsp_write      = write_q;
    assign m00_axi_awaddr = addr_q;
    assign m00_axi_araddr = addr_q;
    assign m00_axi_wdata  = wdata_q;
    assign m00_axi_wstrb  = wstrb_q;
    assign m00_axi_awprot = PROT;
    assign m00_axi_arprot = PROT;

    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            state           <= IDLE;
            write_q         <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            wstrb_q         <= '0;
            aw_done         <= 1'b0;
            w_done          <= 1'b0;
            m00_axi_awvalid <= 1'b0;
            m00_axi_wvalid  <= 1'b0;
            m00_axi_bready  <= 1'b0;
            m00_axi_arvalid <= 1'b0;
            m00_axi_rready  <= 1'b0;
            rsp_valid       <= 1'b0;
            rsp_rdata       <= '0;
            rsp_resp        <= 2'b00;
            rsp_cycles      <= '0;
        end else begin
            // latency counts every clock the bus is busy, saturating
            if (on_bus && !cyc_max) begin
                rsp_cycles <= rsp_cycles + 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        write_q    <= cmd_write;
                        addr_q     <= cmd_addr;
                        wdata_q    <= cmd_wdata;
                        wstrb_q    <= cmd_wstrb;
                        aw_done    <= 1'b0;
                        w_done     <= 1'b0;
                        rsp_cycles <= '0;
                        if (cmd_write) begin
                            m00_axi_awvalid <= 1'b1;
                            m00_axi_wvalid  <= 1'b1;
                            state           <= WR;
                        end else begin
                            m00_axi_arvalid <= 1'b1;
                            state           <= RD_A;
                        end
                    end
                end
                WR: begin
                    if (aw_hs) begin
                        aw_done         <= 1'b1;
                        m00_axi_awvalid <= 1'b0;
                    end
                    if (w_hs) begin
                        w_done         <= 1'b1;
                        m00_axi_wvalid <= 1'b0;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        m00_axi_bready <= 1'b1;
                        state          <= WR_B;
                    end
                end
                WR_B: begin
                    if (b_hs) begin
                        rsp_resp       <= m00_axi_bresp;
                        rsp_rdata      <= '0;
                        m00_axi_bready <= 1'b0;
                        rsp_valid      <= 1'b1;
                        state          <= RSP;
                    end
                end
                RD_A: begin
                    if (ar_hs) begin
                        m00_axi_arvalid <= 1'b0;
                        m00_axi_rready  <= 1'b1;
                        state           <= RD_D;
                    end
                end
                RD_D: begin
                    if (r_hs) begin
                        rsp_rdata      <= m00_axi_rdata;
                        rsp_resp       <= m00_axi_rresp;
                        m00_axi_rready <= 1'b0;
                        rsp_valid      <= 1'b1;
                        state          <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acf_axil_cmd_master.sv
// Bench for acf_axil_cmd_master: configurable AXI-Lite slave model and
// a response scoreboard fed at command issue time.
module tb_acf_axil_cmd_master;

    typedef struct {
        bit          w;
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic [7:0]  cyc;
    } exp_t;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [7:0]  rsp_cycles;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [1:0]  bresp = 2'b00;
    logic        bvalid = 1'b0;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = 2'b00;
    logic        rvalid = 1'b0;
    logic        rready;

    int checks = 0;
    int fails = 0;
    exp_t exp_q[$];

    // slave knobs
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  bresp_v = 2'b00, rresp_v = 2'b00;
    logic [31:0] rdata_v = '0;

    // slave observations
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    int aw_hi = 0, w_hi = 0, wl_ah = 0;
    logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
    logic [3:0]  cap_wstrb = '0;

    acf_axil_cmd_master #(
        .ADDR_W(32), .DATA_W(32), .PROT(3'b000), .CYC_W(8)
    ) dut (
        .m00_axi_aclk    (aclk),
        .m00_axi_aresetn (aresetn),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_write       (cmd_write),
        .cmd_addr        (cmd_addr),
        .cmd_wdata       (cmd_wdata),
        .cmd_wstrb       (cmd_wstrb),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_write       (rsp_write),
        .rsp_rdata       (rsp_rdata),
        .rsp_resp        (rsp_resp),
        .rsp_cycles      (rsp_cycles),
        .m00_axi_awaddr  (awaddr),
        .m00_axi_awprot  (awprot),
        .m00_axi_awvalid (awvalid),
        .m00_axi_awready (awready),
        .m00_axi_wdata   (wdata),
        .m00_axi_wstrb   (wstrb),
        .m00_axi_wvalid  (wvalid),
        .m00_axi_wready  (wready),
        .m00_axi_bresp   (bresp),
        .m00_axi_bvalid  (bvalid),
        .m00_axi_bready  (bready),
        .m00_axi_araddr  (araddr),
        .m00_axi_arprot  (arprot),
        .m00_axi_arvalid (arvalid),
        .m00_axi_arready (arready),
        .m00_axi_rdata   (rdata),
        .m00_axi_rresp   (rresp),
        .m00_axi_rvalid  (rvalid),
        .m00_axi_rready  (rready)
    );

    always #5 aclk = ~aclk;

    // slave model: decides readiness on the falling edge
    always @(negedge aclk) begin
        if (!aresetn) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        end else begin
            if (awvalid) begin
                awready = (aw_cnt >= aw_dly);
                if (!awready) aw_cnt++;
                aw_hi++;
            end else begin
                awready = 0; aw_cnt = 0;
            end
            if (wvalid) begin
                wready = (w_cnt >= w_dly);
                if (!wready) w_cnt++;
                w_hi++;
            end else begin
                wready = 0; w_cnt = 0;
            end
            if (!wvalid && awvalid) wl_ah++;
            if (awvalid && awready) begin
                aw_hs++; cap_awaddr = awaddr;
            end
            if (wvalid && wready) begin
                w_hs++; cap_wdata = wdata; cap_wstrb = wstrb;
            end
            if (bready) begin
                bvalid = (b_cnt >= b_dly);
                if (!bvalid) b_cnt++;
                bresp = bresp_v;
            end else begin
                bvalid = 0; b_cnt = 0;
            end
            if (bvalid && bready) b_hs++;
            if (arvalid) begin
                arready = (ar_cnt >= ar_dly);
                if (!arready) ar_cnt++;
            end else begin
                arready = 0; ar_cnt = 0;
            end
            if (arvalid && arready) begin
                ar_hs++; cap_araddr = araddr;
            end
            if (rready) begin
                rvalid = (r_cnt >= r_dly);
                if (!rvalid) r_cnt++;
                rdata = rdata_v; rresp = rresp_v;
            end else begin
                rvalid = 0; r_cnt = 0;
            end
            if (rvalid && rready) r_hs++;
        end
    end

    function automatic exp_t mk_exp(input bit w);
        exp_t e;
        int c;
        e.w = w;
        if (w) begin
            c = ((aw_dly > w_dly) ? aw_dly : w_dly) + 1 + b_dly + 1;
            e.rdata = '0;
            e.resp = bresp_v;
        end else begin
            c = ar_dly + 1 + r_dly + 1;
            e.rdata = rdata_v;
            e.resp = rresp_v;
        end
        e.cyc = (c > 255) ? 8'd255 : 8'(c);
        return e;
    endfunction

    task automatic issue(input bit w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        cmd_valid = 1; cmd_write = w;
        cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        while (!cmd_ready && n < 1000) begin
            @(negedge aclk); n++;
        end
        checks++;
        if (!cmd_ready) begin
            fails++;
            $display("FAIL issue_timeout: cmd_ready=%0b want 1", cmd_ready);
        end
        @(negedge aclk);
        cmd_valid = 0;
    endtask

    task automatic get_rsp(input string nm);
        exp_t e;
        int n = 0;
        rsp_ready = 1;
        while (!rsp_valid && n < 1000) begin
            @(negedge aclk); n++;
        end
        checks++;
        if (!rsp_valid) begin
            fails++;
            $display("FAIL %s_timeout: rsp_valid=0 want 1", nm);
            rsp_ready = 0;
            return;
        end
        checks++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s_unexpected: queue size 0 want >0", nm);
        end else begin
            e = exp_q.pop_front();
            checks += 4;
            if (rsp_write !== e.w) begin
                fails++;
                $display("FAIL %s_write: got %0b want %0b", nm, rsp_write, e.w);
            end
            if (rsp_rdata !== e.rdata) begin
                fails++;
                $display("FAIL %s_rdata: got %h want %h", nm, rsp_rdata, e.rdata);
            end
            if (rsp_resp !== e.resp) begin
                fails++;
                $display("FAIL %s_resp: got %0d want %0d", nm, rsp_resp, e.resp);
            end
            if (rsp_cycles !== e.cyc) begin
                fails++;
                $display("FAIL %s_cycles: got %0d want %0d", nm, rsp_cycles, e.cyc);
            end
        end
        @(negedge aclk);
        rsp_ready = 0;
    endtask

    task automatic set_knobs(input int a, input int w, input int b,
                             input int ar, input int r);
        aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
    endtask

    task automatic test_reset();
        checks++;
        if ({cmd_ready, rsp_valid, awvalid, wvalid, arvalid, bready, rready}
            !== 7'b1000000) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 1000000",
                {cmd_ready, rsp_valid, awvalid, wvalid, arvalid, bready, rready});
        end
        checks++;
        if (rsp_cycles !== 8'd0 || rsp_rdata !== 32'd0 || rsp_resp !== 2'd0) begin
            fails++;
            $display("FAIL reset_rsp: cyc=%0d rdata=%h resp=%0d want 0",
                rsp_cycles, rsp_rdata, rsp_resp);
        end
    endtask

    task automatic test_write_basic();
        int a0 = aw_hi, w0 = w_hi;
        set_knobs(0, 0, 0, 0, 0); bresp_v = 2'b00;
        exp_q.push_back(mk_exp(1));
        issue(1, 32'h0, 32'h5, 4'hF);
        get_rsp("wr_basic");
        checks++;
        if (aw_hi - a0 != 1 || w_hi - w0 != 1) begin
            fails++;
            $display("FAIL wr_basic_vhigh: aw=%0d w=%0d want 1 1",
                aw_hi - a0, w_hi - w0);
        end
        checks++;
        if (cap_awaddr !== 32'h0 || cap_wdata !== 32'h5 || cap_wstrb !== 4'hF) begin
            fails++;
            $display("FAIL wr_basic_bus: addr=%h data=%h strb=%h want 0 5 f",
                cap_awaddr, cap_wdata, cap_wstrb);
        end
    endtask

    task automatic test_write_skew();
        int a0 = aw_hs, w0 = w_hs, b0 = b_hs, l0 = wl_ah;
        set_knobs(3, 0, 0, 0, 0); bresp_v = 2'b00;
        exp_q.push_back(mk_exp(1));
        issue(1, 32'h10, 32'hA5A5_0001, 4'h0);
        get_rsp("wr_skew");
        checks++;
        if (aw_hs - a0 != 1 || w_hs - w0 != 1 || b_hs - b0 != 1) begin
            fails++;
            $display("FAIL wr_skew_hs: aw=%0d w=%0d b=%0d want 1 1 1",
                aw_hs - a0, w_hs - w0, b_hs - b0);
        end
        checks++;
        if (wl_ah - l0 != 3) begin
            fails++;
            $display("FAIL wr_skew_wlow: got %0d want 3", wl_ah - l0);
        end
        checks++;
        if (cap_wstrb !== 4'h0 || cap_awaddr !== 32'h10) begin
            fails++;
            $display("FAIL wr_skew_bus: strb=%h addr=%h want 0 10",
                cap_wstrb, cap_awaddr);
        end
    endtask

    task automatic test_read();
        set_knobs(0, 0, 0, 2, 0);
        rdata_v = 32'hDEAD_BEEF; rresp_v = 2'b00;
        exp_q.push_back(mk_exp(0));
        issue(0, 32'h4, 32'hFFFF_FFFF, 4'hF);
        get_rsp("rd");
        checks++;
        if (cap_araddr !== 32'h4 || arprot !== 3'b000 || awprot !== 3'b000) begin
            fails++;
            $display("FAIL rd_addr: addr=%h prot=%0d want 4 0", cap_araddr, arprot);
        end
    endtask

    task automatic test_rsp_hold();
        exp_t e;
        int n = 0, r0;
        set_knobs(1, 2, 1, 0, 0); bresp_v = 2'b01;
        exp_q.push_back(mk_exp(1));
        issue(1, 32'h20, 32'h1234_5678, 4'h3);
        while (!rsp_valid && n < 100) begin
            @(negedge aclk); n++;
        end
        e = exp_q[0];
        rdata_v = 32'h0BAD_F00D; rresp_v = 2'b00;
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h8;
        r0 = ar_hs;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_write !== e.w ||
                rsp_resp !== e.resp || rsp_cycles !== e.cyc ||
                rsp_rdata !== e.rdata) begin
                fails++;
                $display("FAIL hold_%0d: v=%0b rdy=%0b resp=%0d cyc=%0d want 1 0 %0d %0d",
                    i, rsp_valid, cmd_ready, rsp_resp, rsp_cycles, e.resp, e.cyc);
            end
            @(negedge aclk);
        end
        checks++;
        if (ar_hs != r0) begin
            fails++;
            $display("FAIL hold_early_accept: ar_hs=%0d want %0d", ar_hs, r0);
        end
        rsp_ready = 1;
        @(negedge aclk);
        rsp_ready = 0;
        void'(exp_q.pop_front());
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL hold_release: v=%0b rdy=%0b want 0 1", rsp_valid, cmd_ready);
        end
        set_knobs(0, 0, 0, 0, 0);
        exp_q.push_back(mk_exp(0));
        @(negedge aclk);
        cmd_valid = 0;
        checks++;
        if (cmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL hold_accept: cmd_ready=%0b want 0", cmd_ready);
        end
        get_rsp("hold_next");
    endtask

    task automatic test_reset_mid();
        int n = 0;
        set_knobs(0, 0, 20, 0, 0);
        issue(1, 32'h30, 32'h77, 4'hF);
        while (!bready && n < 100) begin
            @(negedge aclk); n++;
        end
        @(negedge aclk);
        aresetn = 0;
        #1;
        checks++;
        if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid} !== 6'b0) begin
            fails++;
            $display("FAIL rst_mid_drop: got %b want 000000",
                {awvalid, wvalid, bready, arvalid, rready, rsp_valid});
        end
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_ready: got %0b want 1", cmd_ready);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            checks++;
            if (rsp_valid !== 1'b0) begin
                fails++;
                $display("FAIL rst_mid_norsp: rsp_valid=%0b want 0", rsp_valid);
            end
        end
        set_knobs(0, 0, 0, 1, 1);
        rdata_v = 32'hCAFE_0042; rresp_v = 2'b00;
        exp_q.push_back(mk_exp(0));
        issue(0, 32'h44, 32'h0, 4'h0);
        get_rsp("rst_mid_read");
    endtask

    task automatic test_saturate_and_error();
        set_knobs(0, 0, 0, 300, 0);
        rdata_v = 32'h5555_AAAA; rresp_v = 2'b11;
        exp_q.push_back(mk_exp(0));
        issue(0, 32'h50, 32'h0, 4'h0);
        get_rsp("sat_read");
        set_knobs(0, 1, 2, 0, 0);
        bresp_v = 2'b10;
        exp_q.push_back(mk_exp(1));
        issue(1, 32'h54, 32'h9, 4'h1);
        get_rsp("slverr_write");
    endtask

    task automatic test_back_to_back();
        int total = 8;
        rsp_ready = 1;
        fork
            begin
                for (int i = 0; i < total; i++) begin
                    int n = 0;
                    bit w;
                    while (!cmd_ready && n < 1000) begin
                        @(negedge aclk); n++;
                    end
                    w = 1'($urandom_range(0, 1));
                    set_knobs($urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom_range(0, 3));
                    bresp_v = 2'($urandom_range(0, 3));
                    rresp_v = 2'($urandom_range(0, 3));
                    rdata_v = $urandom;
                    exp_q.push_back(mk_exp(w));
                    issue(w, $urandom & 32'hFFFC, $urandom, 4'($urandom));
                end
            end
            begin
                for (int i = 0; i < total; i++) begin
                    get_rsp("b2b");
                    rsp_ready = 1;
                end
            end
        join
        rsp_ready = 0;
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL b2b_leftover: queue size %0d want 0", exp_q.size());
        end
    endtask

    initial begin
        repeat (3) @(negedge aclk);
        #1;
        test_reset();
        @(negedge aclk);
        aresetn = 1;
        @(negedge aclk);
        test_write_basic();
        test_write_skew();
        test_read();
        test_rsp_hold();
        test_reset_mid();
        test_saturate_and_error();
        test_back_to_back();
        repeat (2) @(negedge aclk);
        $display("End of test - %0d assertions evaluated, %0d failures",
            checks, fails);
        $finish;
    end

endmodule
